// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//
// Sequential unsigned integer divider. It computes quotient and remainder by
// restoring shift-subtract, one quotient bit per clock. It uses the same
// start/ready handshake as the shift-add multiplier that sits beside it in the
// arithmetic datapath. A zero divisor bypasses the iteration entirely and
// reports through div_by_zero.
//
// Handshake (start/ready):
//   start is sampled only while the FSM is IDLE. A request seen there is
//   accepted on that edge, and the operands are captured on that same edge.
//   After acceptance the operand inputs may change freely. While busy is high,
//   any start is ignored and is not queued; the requester must hold or
//   re-assert start until the block returns to IDLE.
//   ready is a single-cycle pulse. It coincides with quotient, remainder and
//   div_by_zero being updated. These three outputs then hold their values until
//   the next completion or reset.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous reset, active-high; aborts any division in flight
//   start        request, sampled only in IDLE
//   busy         high while the FSM is in RUN or DONE
//   ready        one-cycle pulse: results are valid and freshly updated
//   dividend     unsigned dividend, captured at an accepted start
//   divisor      unsigned divisor, captured at an accepted start
//   quotient     registered quotient ({N{1'b1}} on divide-by-zero)
//   remainder    registered remainder (the dividend on divide-by-zero)
//   div_by_zero  set together with the results when the captured divisor was 0
//   state_dbg    current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
// -----------------------------------------------------------------------------
module divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic [1:0]   state_dbg
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Working registers. q_reg starts out holding the dividend. Each iteration
  // shifts it left, and the new quotient bit enters at the bottom, so after N
  // steps it holds the quotient.
  logic [N-1:0]  q_reg;
  logic [N:0]    r_reg;
  logic [N-1:0]  d_reg;
  logic [CW-1:0] cnt;

  // One restoring step, computed combinationally from the current registers.
  logic [N:0]    trial;
  logic [N:0]    trial_diff;
  logic          trial_ge;
  logic [N:0]    r_step;
  logic [N-1:0]  q_step;
  logic          last_iter;
  logic          divisor_zero;

  // The partial remainder is always below the divisor, so r_reg[N] is zero
  // between steps. The step therefore shifts only the low N bits. The extra
  // bit of trial catches the bit shifted out, which is what lets the
  // comparison against the divisor see the full N+1-bit value.
  always_comb begin
    trial      = {r_reg[N-1:0], q_reg[N-1]};
    trial_diff = trial - {1'b0, d_reg};
    trial_ge   = (trial >= {1'b0, d_reg});
    r_step     = trial_ge ? trial_diff : trial;
    q_step     = {q_reg[N-2:0], trial_ge};
  end

  assign last_iter    = (cnt == CW'(N - 1));
  assign divisor_zero = (divisor == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          // A zero divisor produces its result immediately and goes straight
          // to DONE, so busy and the return to IDLE behave the same way as
          // for a normal division.
          state_nxt = divisor_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      ready       <= 1'b0;
    end else begin
      // ready is a pulse: it is only held high on a completion edge.
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              ready       <= 1'b1;
            end else begin
              q_reg <= dividend;
              r_reg <= '0;
              d_reg <= divisor;
              cnt   <= '0;
            end
          end
        end
        RUN: begin
          q_reg <= q_step;
          r_reg <= r_step;
          cnt   <= cnt + CW'(1);
          if (last_iter) begin
            // Publish the results of the step that completes on this edge.
            // The registered q_reg/r_reg are not final until after it.
            quotient    <= q_step;
            remainder   <= r_step[N-1:0];
            div_by_zero <= 1'b0;
            ready       <= 1'b1;
          end
        end
        default: begin
          // DONE: one cycle only. The results simply hold.
        end
      endcase
    end
  end

  // The partial remainder stays below the divisor, so its top bit never
  // survives a step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_reg[N] == 1'b0);
    end
  end

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//
// Bench for the sequential divider. It uses two instances, one with N=4 and
// one with N=8. Expected values come from a constant vector table, from
// hand-written sequences (start held through RUN, reset in the middle of
// RUN), and from random operands checked against a plain-arithmetic model.
// -----------------------------------------------------------------------------
module tb_divider;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start4, busy4, ready4, dz4;
  logic [3:0] a4, b4, q4, r4;
  logic [1:0] st4;

  logic       start8, busy8, ready8, dz8;
  logic [7:0] a8, b8, q8, r8;
  logic [1:0] st8;

  divider #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .ready(ready4),
    .dividend(a4), .divisor(b4), .quotient(q4), .remainder(r4),
    .div_by_zero(dz4), .state_dbg(st4)
  );

  divider #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .ready(ready8),
    .dividend(a8), .divisor(b8), .quotient(q8), .remainder(r8),
    .div_by_zero(dz8), .state_dbg(st8)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver / sampler tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin
      start4 = s; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      start8 = s; a8 = a; b8 = b;
    end
  endtask

  task automatic sample(input int w, output logic rdy, output logic bsy, output logic dz,
                        output logic [7:0] q, output logic [7:0] r, output logic [1:0] st);
    if (w == 4) begin
      rdy = ready4; bsy = busy4; dz = dz4; q = {4'b0, q4}; r = {4'b0, r4}; st = st4;
    end else begin
      rdy = ready8; bsy = busy8; dz = dz8; q = q8; r = r8; st = st8;
    end
  endtask

  // Issues one request from IDLE with a single-cycle start. Latency is the
  // number of edges after the capture edge at which ready is first seen.
  // busy_cyc counts the post-edge samples with busy high, starting from the
  // capture edge. clean_end reports that one edge after ready the block is
  // back in IDLE with ready low.
  task automatic do_div(input int w, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r, output logic dz,
                        output int lat, output int busy_cyc, output logic clean_end);
    logic       rdy, bsy, dzs;
    logic [7:0] qs, rs;
    logic [1:0] st;
    @(negedge clk);
    drive(w, 1'b1, a, b);
    @(posedge clk);
    #1;
    // Operands are scrambled after capture; results must not depend on them.
    drive(w, 1'b0, 8'($urandom), 8'($urandom));
    lat = 0;
    busy_cyc = 0;
    sample(w, rdy, bsy, dzs, qs, rs, st);
    if (bsy) busy_cyc++;
    while (!rdy && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      sample(w, rdy, bsy, dzs, qs, rs, st);
      if (bsy) busy_cyc++;
    end
    q = qs; r = rs; dz = dzs;
    @(posedge clk);
    #1;
    sample(w, rdy, bsy, dzs, qs, rs, st);
    clean_end = !rdy && !bsy && (st == 2'd0);
  endtask

  // Runs one request and checks it against the supplied expectations.
  task automatic run_and_check(input string tag, input int w, input int a, input int b,
                               input int eq, input int er, input int edz, input int elat);
    logic [7:0] q, r;
    logic       dz, clean;
    int         lat, bcyc;
    do_div(w, 8'(a), 8'(b), q, r, dz, lat, bcyc, clean);
    check({tag, " quotient"}, 32'(q), 32'(eq));
    check({tag, " remainder"}, 32'(r), 32'(er));
    check({tag, " div_by_zero"}, 32'(dz), 32'(edz));
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " busy cycles"}, 32'(bcyc), 32'(elat + 1));
    check({tag, " back to idle"}, 32'(clean), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int w;
    int a;
    int b;
    int eq;
    int er;
    int edz;
    int elat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int pulses;
    int lat;
    logic [7:0] pq, pr;
    logic seen_ready;

    rst = 1'b1;
    drive(4, 1'b0, 8'd0, 8'd0);
    drive(8, 1'b0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("reset ready4", 32'(ready4), 32'd0);
    check("reset busy4", 32'(busy4), 32'd0);
    check("reset quotient4", 32'(q4), 32'd0);
    check("reset remainder4", 32'(r4), 32'd0);
    check("reset dz4", 32'(dz4), 32'd0);
    check("reset state4", 32'(st4), 32'd0);
    check("reset ready8", 32'(ready8), 32'd0);
    check("reset quotient8", 32'(q8), 32'd0);
    rst = 1'b0;

    // Table vectors (w, a, b, quotient, remainder, div_by_zero, latency)
    vecs.push_back('{4, 13, 4, 3, 1, 0, 4});
    vecs.push_back('{4, 15, 1, 15, 0, 0, 4});
    vecs.push_back('{4, 15, 15, 1, 0, 0, 4});
    vecs.push_back('{4, 3, 9, 0, 3, 0, 4});
    vecs.push_back('{4, 0, 5, 0, 0, 0, 4});
    vecs.push_back('{4, 7, 0, 15, 7, 1, 0});
    vecs.push_back('{4, 9, 2, 4, 1, 0, 4});
    vecs.push_back('{8, 255, 16, 15, 15, 0, 8});
    vecs.push_back('{8, 200, 7, 28, 4, 0, 8});
    vecs.push_back('{8, 1, 255, 0, 1, 0, 8});
    vecs.push_back('{8, 77, 0, 255, 77, 1, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].b,
                    vecs[i].eq, vecs[i].er, vecs[i].edz, vecs[i].elat);
    end

    // Start held high through RUN, operands changed to 1/1 after capture.
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd13; b4 = 4'd4;
    @(posedge clk);
    #1;
    a4 = 4'd1; b4 = 4'd1;
    pulses = 0;
    pq = '0; pr = '0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      if (ready4) begin
        pulses++;
        pq = {4'b0, q4};
        pr = {4'b0, r4};
        check("held start ready edge", 32'(e), 32'd4);
      end
    end
    check("held start one pulse", 32'(pulses), 32'd1);
    check("held start quotient", 32'(pq), 32'd3);
    check("held start remainder", 32'(pr), 32'd1);
    check("held start idle before reaccept", 32'(busy4), 32'd0);
    @(posedge clk);
    #1;
    check("held start reaccepted", 32'(busy4), 32'd1);
    start4 = 1'b0;
    lat = 0;
    while (!ready4 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("second request latency", 32'(lat), 32'd4);
    check("second request quotient", 32'(q4), 32'd1);
    check("second request remainder", 32'(r4), 32'd0);
    @(posedge clk);
    #1;
    check("second request idle", 32'(st4), 32'd0);

    // Reset asserted during the second RUN cycle of 14/3.
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd14; b4 = 4'd3;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    @(posedge clk);
    #1;
    check("abort in run", 32'(st4), 32'd1);
    seen_ready = ready4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    seen_ready = seen_ready | ready4;
    check("abort no ready", 32'(seen_ready), 32'd0);
    check("abort busy", 32'(busy4), 32'd0);
    check("abort quotient", 32'(q4), 32'd0);
    check("abort remainder", 32'(r4), 32'd0);
    check("abort dz", 32'(dz4), 32'd0);
    check("abort state", 32'(st4), 32'd0);
    rst = 1'b0;
    run_and_check("after abort 14/3", 4, 14, 3, 4, 2, 0, 4);

    // Random operands against an arithmetic model.
    for (int i = 0; i < 24; i++) begin
      int w, a, b, eq, er, edz, elat;
      w = (i % 2 == 1) ? 8 : 4;
      a = int'($urandom_range(0, (1 << w) - 1));
      b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, (1 << w) - 1));
      if (b == 0) begin
        eq = (1 << w) - 1; er = a; edz = 1; elat = 0;
      end else begin
        eq = a / b; er = a % b; edz = 0; elat = w;
      end
      run_and_check($sformatf("rand%0d n%0d %0d/%0d", i, w, a, b), w, a, b, eq, er, edz, elat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential unsigned integer divider: the inverse of the team's shift-add multiplier, sharing its start/ready handshake. Computes quotient and remainder by restoring shift-subtract, one quotient bit per clock, with an explicit divide-by-zero path. It sits beside the multiplier in the arithmetic datapath and is driven by the same control logic.

## Interface

- N, 4, operand width in bits; quotient and remainder are also N bits.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- busy  output  1  high while in RUN or DONE.
- ready  output  1  one-cycle pulse: results valid and updated.
- dividend  input  N  unsigned dividend; captured at accepted start.
- divisor  input  N  unsigned divisor; captured at accepted start.
- quotient  output  N  registered quotient; held until the next completion.
- remainder  output  N  registered remainder; held until the next completion.
- div_by_zero  output  1  set with results when the captured divisor is 0; held with results.

## Operation

- States: IDLE, RUN, DONE.
- Internal registers:
  - q_reg (N bits) holds the dividend, then the quotient.
  - r_reg (N+1 bits) is the partial remainder.
  - d_reg (N bits) holds the divisor.
  - cnt counts 0..N-1, width clog2(N)+1.
- IDLE, start=1, divisor≠0:
  - Load q_reg=dividend, r_reg=0, d_reg=divisor, cnt=0.
  - Next state RUN.
- IDLE, start=1, divisor=0:
  - No iteration.
  - On that same edge write quotient={N{1'b1}}, remainder=dividend, div_by_zero=1, ready=1.
  - Next state DONE.
- IDLE, start=0: no change; ready=0.
- RUN, each edge:
  - t = {r_reg[N-1:0], q_reg[N-1]}.
  - Shift q_reg left by 1.
  - If t ≥ {1'b0,d_reg}: r_reg = t − d_reg and q_reg[0]=1. Otherwise r_reg=t and q_reg[0]=0.
  - cnt increments.
- RUN, edge where cnt=N-1:
  - The iteration above completes.
  - Write quotient=final q_reg, remainder=final r_reg[N-1:0], div_by_zero=0, ready=1.
  - Next state DONE.
- DONE: one cycle only; ready cleared; next state IDLE.
- Arithmetic: all unsigned. The N+1-bit r_reg absorbs the shift carry. Results satisfy dividend = quotient·divisor + remainder and remainder < divisor.
- start in RUN or DONE is ignored. It is not queued; the requester must re-assert in IDLE.
- Operand inputs may change freely after the capture edge.

## Timing

- Reset values:
  - ready=0, busy=0, quotient=0, remainder=0, div_by_zero=0.
  - State IDLE; internal registers 0.
- rst has priority over every other event. Reset mid-RUN aborts: no ready pulse, and outputs return to 0.
- Normal latency:
  - Start captured at edge k.
  - ready and results visible after edge k+N.
  - ready low again after edge k+N+1; IDLE from then.
- Divide-by-zero latency: ready and results visible after edge k itself, i.e. the cycle after start was sampled.
- Throughput: next start is accepted at edge k+N+2 (normal) or k+2 (div-by-zero).
- busy is high from after edge k until after the edge that leaves DONE.
- Output registers change only on a completion edge or on reset.

## Test plan

- N=4, 13/4, start one cycle:
  - ready exactly 4 edges after capture, lasting 1 cycle.
  - quotient=3, remainder=1, div_by_zero=0.
  - busy high for 5 cycles.
- N=4 boundary set: 15/1→(15,0); 15/15→(1,0); 3/9→(0,3); 0/5→(0,0). Each takes identical latency.
- N=4, 7/0:
  - ready in the cycle after capture.
  - quotient=15, remainder=7, div_by_zero=1.
  - A subsequent 9/2 gives (4,1) with div_by_zero=0.
- start held high during RUN, with the operands changed mid-RUN to 1/1:
  - The first request's results are unaffected.
  - Exactly one ready pulse per accepted start.
  - The held start is accepted again only from IDLE.
- rst asserted on the 2nd RUN cycle of 14/3:
  - No ready pulse; all outputs 0; state IDLE.
  - A fresh 14/3 then yields (4,2).
- N=8: 255/16→(15,15) after 8 edges; 200/7→(28,4); 1/255→(0,1).
